// File: rtl/b_history_state_if.sv
// Predictor/backend-facing bundle for the branch history state stage.
// The master drives the predictor results and backend resolve info; the slave returns the registered state.
interface b_history_state_if #(
    parameter int GHR_DEPTH = 20,
    parameter int ENTRY_W   = 9
);
    logic                          fetchReady;
    logic [31:0]                   nextPc;
    logic [4*ENTRY_W-1:0]          newGhrEntry;
    logic [2:0]                    newPassBNum;
    logic [7:0]                    newPendingB;
    logic                          gotErr;
    logic                          resolveValid;
    logic [2:0]                    resolveCount;
    logic                          mispredict;
    logic [31:0]                   mispredictPc;

    logic                          fetchValid;
    logic [31:0]                   currentPc;
    logic [GHR_DEPTH*ENTRY_W-1:0]  globalHistoryRegister;
    logic [7:0]                    pendingB;
    logic [2:0]                    counter;
    logic [31:0]                   correctPc;

    modport master (
        output fetchReady, nextPc, newGhrEntry, newPassBNum, newPendingB, gotErr,
               resolveValid, resolveCount, mispredict, mispredictPc,
        input  fetchValid, currentPc, globalHistoryRegister, pendingB, counter, correctPc
    );

    modport slave (
        input  fetchReady, nextPc, newGhrEntry, newPassBNum, newPendingB, gotErr,
               resolveValid, resolveCount, mispredict, mispredictPc,
        output fetchValid, currentPc, globalHistoryRegister, pendingB, counter, correctPc
    );
endinterface

// File: rtl/b_history_state.sv
// Registered state behind the branch predictor: fetch PC, global history, pending/resolved B
// counts and the latched mispredict redirect target, committed on every accepted fetch group.
module b_history_state #(
    parameter int          GHR_DEPTH = 20,
    parameter int          ENTRY_W   = 9,
    parameter logic [31:0] PC_RESET  = 32'h0000_0000
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    b_history_state_if.slave bus
);
    localparam int GHR_W = GHR_DEPTH * ENTRY_W;
    localparam int NEW_W = 4 * ENTRY_W;

    typedef enum logic [1:0] {RUN, REDIRECT, FLUSH} stateT;

    stateT              state;
    stateT              nextState;
    logic [31:0]        pc;
    logic [31:0]        correctPc;
    logic [GHR_W-1:0]   ghr;
    logic [GHR_W-1:0]   ghrNext;
    logic [NEW_W-1:0]   insertMask;
    logic [7:0]         pendingB;
    logic [2:0]         counter;
    logic [2:0]         counterNext;
    logic [3:0]         counterSum;
    logic               fetchValid;
    logic               fire;
    logic               mispredictEvt;

    assign fetchValid    = (state != FLUSH);
    assign fire          = fetchValid & bus.fetchReady;
    assign mispredictEvt = bus.resolveValid & bus.mispredict;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= FLUSH;
        else          state <= nextState;
    end

    // A mispredict always wins: it either enters REDIRECT or refreshes the target while there.
    always_comb begin
        nextState = state;
        case (state)
            RUN:      if (mispredictEvt) nextState = REDIRECT;
            REDIRECT: begin
                if (mispredictEvt)  nextState = REDIRECT;
                else if (fire)      nextState = FLUSH;
            end
            FLUSH:    nextState = mispredictEvt ? REDIRECT : RUN;
            default:  nextState = FLUSH;
        endcase
    end

    always_comb begin
        insertMask = '0;
        for (int k = 0; k < 4; k++) begin
            if (k < int'(bus.newPassBNum)) insertMask[k*ENTRY_W +: ENTRY_W] = '1;
        end
    end

    // On error the speculative entries sit at the young end, so shift them out toward entry 0.
    always_comb begin
        ghrNext = ghr;
        if (bus.gotErr) begin
            if (bus.newPendingB >= 8'(GHR_DEPTH)) ghrNext = '0;
            else ghrNext = ghr >> (ENTRY_W * int'(bus.newPendingB));
        end else if (bus.newPassBNum <= 3'd4) begin
            ghrNext = (ghr << (ENTRY_W * int'(bus.newPassBNum)))
                    | GHR_W'(bus.newGhrEntry & insertMask);
        end
    end

    assign counterSum = {1'b0, counter} + {1'b0, bus.resolveCount};

    always_comb begin
        counterNext = counter;
        if (fire)                  counterNext = bus.resolveValid ? bus.resolveCount : 3'd0;
        else if (bus.resolveValid) counterNext = (counterSum > 4'd7) ? 3'd7 : counterSum[2:0];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pc        <= PC_RESET;
            ghr       <= '0;
            pendingB  <= '0;
            counter   <= '0;
            correctPc <= '0;
        end else begin
            counter <= counterNext;
            if (fire) begin
                pc       <= bus.gotErr ? correctPc : bus.nextPc;
                pendingB <= bus.newPendingB;
                ghr      <= ghrNext;
            end
            if (mispredictEvt)            correctPc <= bus.mispredictPc;
            else if (fire && bus.gotErr)  correctPc <= '0;
        end
    end

    assign bus.fetchValid            = fetchValid;
    assign bus.currentPc             = pc;
    assign bus.globalHistoryRegister = ghr;
    assign bus.pendingB              = pendingB;
    assign bus.counter               = counter;
    assign bus.correctPc             = correctPc;
endmodule

// File: tb/tb_b_history_state.sv
// Directed bench for b_history_state: reset, GHR insert/discard, resolved-B counter, redirect flow.
module tb_b_history_state;
    logic clk;
    logic rstN;
    int   checks;
    int   errors;

    b_history_state_if #(.GHR_DEPTH(20), .ENTRY_W(9)) bus ();

    b_history_state dut (
        .i_clk   (clk),
        .i_rst_n (rstN),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs();
        bus.fetchReady   = 1'b0;
        bus.nextPc       = 32'h0;
        bus.newGhrEntry  = 36'h0;
        bus.newPassBNum  = 3'd0;
        bus.newPendingB  = 8'd0;
        bus.gotErr       = 1'b0;
        bus.resolveValid = 1'b0;
        bus.resolveCount = 3'd0;
        bus.mispredict   = 1'b0;
        bus.mispredictPc = 32'h0;
    endtask

    task automatic test_reset();
        rstN = 1'b0;
        idleInputs();
        #12;
        checks++; if (bus.fetchValid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid actual %b required 0", bus.fetchValid); end
        checks++; if (bus.currentPc !== 32'h0) begin errors++; $display("[TB] FAIL reset_pc actual %h required 0", bus.currentPc); end
        checks++; if (bus.globalHistoryRegister !== 180'h0) begin errors++; $display("[TB] FAIL reset_ghr actual %h required 0", bus.globalHistoryRegister); end
        checks++; if (bus.pendingB !== 8'h0) begin errors++; $display("[TB] FAIL reset_pendingB actual %h required 0", bus.pendingB); end
        checks++; if (bus.counter !== 3'h0) begin errors++; $display("[TB] FAIL reset_counter actual %h required 0", bus.counter); end
        checks++; if (bus.correctPc !== 32'h0) begin errors++; $display("[TB] FAIL reset_correctPc actual %h required 0", bus.correctPc); end
        rstN = 1'b1;
        #1;
        checks++; if (bus.fetchValid !== 1'b0) begin errors++; $display("[TB] FAIL flush_bubble actual %b required 0", bus.fetchValid); end
        tick();
        checks++; if (bus.fetchValid !== 1'b1) begin errors++; $display("[TB] FAIL run_after_flush actual %b required 1", bus.fetchValid); end
    endtask

    task automatic test_ghr_insert();
        bus.fetchReady  = 1'b1;
        bus.newPassBNum = 3'd1;
        bus.newGhrEntry = {9'h0, 9'h0, 9'h0, 9'h055};
        bus.nextPc      = 32'h100;
        bus.newPendingB = 8'd1;
        tick();
        checks++; if (bus.globalHistoryRegister !== 180'h055) begin errors++; $display("[TB] FAIL ghr_first actual %h required 055", bus.globalHistoryRegister); end
        checks++; if (bus.currentPc !== 32'h100) begin errors++; $display("[TB] FAIL pc_first actual %h required 100", bus.currentPc); end
        checks++; if (bus.pendingB !== 8'd1) begin errors++; $display("[TB] FAIL pendingB_first actual %0d required 1", bus.pendingB); end

        bus.newPassBNum = 3'd2;
        bus.newGhrEntry = {9'h0, 9'h0, 9'h0F1, 9'h1A3};
        bus.nextPc      = 32'h108;
        bus.newPendingB = 8'd3;
        tick();
        checks++; if (bus.globalHistoryRegister !== 180'({9'h055, 9'h0F1, 9'h1A3})) begin errors++; $display("[TB] FAIL ghr_two actual %h required %h", bus.globalHistoryRegister, 180'({9'h055, 9'h0F1, 9'h1A3})); end

        bus.newPassBNum = 3'd0;
        bus.newGhrEntry = {9'h1FF, 9'h1FF, 9'h1FF, 9'h1FF};
        bus.nextPc      = 32'h10C;
        tick();
        checks++; if (bus.globalHistoryRegister !== 180'({9'h055, 9'h0F1, 9'h1A3})) begin errors++; $display("[TB] FAIL ghr_zero_insert actual %h required %h", bus.globalHistoryRegister, 180'({9'h055, 9'h0F1, 9'h1A3})); end

        bus.newPassBNum = 3'd1;
        bus.newGhrEntry = {9'h1FF, 9'h1FF, 9'h1FF, 9'h011};
        bus.nextPc      = 32'h110;
        tick();
        checks++; if (bus.globalHistoryRegister !== 180'({9'h055, 9'h0F1, 9'h1A3, 9'h011})) begin errors++; $display("[TB] FAIL ghr_masked actual %h required %h", bus.globalHistoryRegister, 180'({9'h055, 9'h0F1, 9'h1A3, 9'h011})); end

        bus.fetchReady = 1'b0;
        bus.nextPc     = 32'hBEEF;
        bus.newPendingB = 8'd9;
        tick();
        checks++; if (bus.currentPc !== 32'h110) begin errors++; $display("[TB] FAIL pc_hold actual %h required 110", bus.currentPc); end
        checks++; if (bus.pendingB !== 8'd3) begin errors++; $display("[TB] FAIL pendingB_hold actual %0d required 3", bus.pendingB); end
    endtask

    task automatic test_counter();
        idleInputs();
        bus.resolveValid = 1'b1;
        bus.resolveCount = 3'd3;
        tick();
        checks++; if (bus.counter !== 3'd3) begin errors++; $display("[TB] FAIL counter_3 actual %0d required 3", bus.counter); end
        tick();
        checks++; if (bus.counter !== 3'd6) begin errors++; $display("[TB] FAIL counter_6 actual %0d required 6", bus.counter); end
        tick();
        checks++; if (bus.counter !== 3'd7) begin errors++; $display("[TB] FAIL counter_sat actual %0d required 7", bus.counter); end
        bus.fetchReady   = 1'b1;
        bus.resolveCount = 3'd2;
        bus.nextPc       = 32'h120;
        bus.newPendingB  = 8'd3;
        tick();
        checks++; if (bus.counter !== 3'd2) begin errors++; $display("[TB] FAIL counter_fire actual %0d required 2", bus.counter); end
        checks++; if (bus.currentPc !== 32'h120) begin errors++; $display("[TB] FAIL counter_fire_pc actual %h required 120", bus.currentPc); end
        idleInputs();
        tick();
        checks++; if (bus.counter !== 3'd2) begin errors++; $display("[TB] FAIL counter_idle actual %0d required 2", bus.counter); end
    endtask

    task automatic test_redirect();
        bus.resolveValid = 1'b1;
        bus.resolveCount = 3'd1;
        bus.mispredict   = 1'b1;
        bus.mispredictPc = 32'h0000_1040;
        tick();
        idleInputs();
        checks++; if (bus.correctPc !== 32'h1040) begin errors++; $display("[TB] FAIL redirect_latch actual %h required 1040", bus.correctPc); end
        checks++; if (bus.counter !== 3'd3) begin errors++; $display("[TB] FAIL redirect_counter actual %0d required 3", bus.counter); end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (bus.correctPc !== 32'h1040 || bus.fetchValid !== 1'b1) begin errors++; $display("[TB] FAIL redirect_hold%0d actual %h/%b required 1040/1", i, bus.correctPc, bus.fetchValid); end
        end
        bus.fetchReady  = 1'b1;
        bus.gotErr      = 1'b1;
        bus.newPendingB = 8'd3;
        bus.nextPc      = 32'hDEAD;
        tick();
        idleInputs();
        checks++; if (bus.currentPc !== 32'h1040) begin errors++; $display("[TB] FAIL err_pc actual %h required 1040", bus.currentPc); end
        checks++; if (bus.globalHistoryRegister !== 180'h055) begin errors++; $display("[TB] FAIL err_ghr_shift actual %h required 055", bus.globalHistoryRegister); end
        checks++; if (bus.correctPc !== 32'h0) begin errors++; $display("[TB] FAIL err_correct_clear actual %h required 0", bus.correctPc); end
        checks++; if (bus.pendingB !== 8'd3) begin errors++; $display("[TB] FAIL err_pendingB actual %0d required 3", bus.pendingB); end
        checks++; if (bus.counter !== 3'd0) begin errors++; $display("[TB] FAIL err_counter actual %0d required 0", bus.counter); end
        checks++; if (bus.fetchValid !== 1'b0) begin errors++; $display("[TB] FAIL err_flush actual %b required 0", bus.fetchValid); end
        tick();
        checks++; if (bus.fetchValid !== 1'b1) begin errors++; $display("[TB] FAIL err_run actual %b required 1", bus.fetchValid); end
    endtask

    task automatic test_back_to_back();
        bus.fetchReady  = 1'b1;
        bus.newPassBNum = 3'd4;
        bus.newGhrEntry = {9'h104, 9'h103, 9'h102, 9'h101};
        bus.newPendingB = 8'd4;
        bus.nextPc      = 32'h2000;
        tick();
        idleInputs();
        checks++; if (bus.globalHistoryRegister !== 180'({9'h055, 9'h104, 9'h103, 9'h102, 9'h101})) begin errors++; $display("[TB] FAIL ghr_four actual %h required %h", bus.globalHistoryRegister, 180'({9'h055, 9'h104, 9'h103, 9'h102, 9'h101})); end
        bus.resolveValid = 1'b1;
        bus.resolveCount = 3'd1;
        bus.mispredict   = 1'b1;
        bus.mispredictPc = 32'h3000;
        tick();
        bus.mispredictPc = 32'h3100;
        tick();
        checks++; if (bus.correctPc !== 32'h3100 || bus.fetchValid !== 1'b1) begin errors++; $display("[TB] FAIL redirect_overwrite actual %h/%b required 3100/1", bus.correctPc, bus.fetchValid); end
        bus.fetchReady   = 1'b1;
        bus.gotErr       = 1'b1;
        bus.newPendingB  = 8'd25;
        bus.mispredictPc = 32'h4000;
        tick();
        idleInputs();
        checks++; if (bus.globalHistoryRegister !== 180'h0) begin errors++; $display("[TB] FAIL err_big_clear actual %h required 0", bus.globalHistoryRegister); end
        checks++; if (bus.currentPc !== 32'h3100) begin errors++; $display("[TB] FAIL err_big_pc actual %h required 3100", bus.currentPc); end
        checks++; if (bus.correctPc !== 32'h4000) begin errors++; $display("[TB] FAIL err_same_mispredict actual %h required 4000", bus.correctPc); end
        checks++; if (bus.fetchValid !== 1'b1) begin errors++; $display("[TB] FAIL err_stay_redirect actual %b required 1", bus.fetchValid); end
        checks++; if (bus.counter !== 3'd1) begin errors++; $display("[TB] FAIL err_big_counter actual %0d required 1", bus.counter); end
        tick();
        checks++; if (bus.fetchValid !== 1'b1 || bus.correctPc !== 32'h4000) begin errors++; $display("[TB] FAIL redirect_persist actual %b/%h required 1/4000", bus.fetchValid, bus.correctPc); end
    endtask

    task automatic test_async_reset();
        #2;
        rstN = 1'b0;
        #1;
        checks++; if (bus.fetchValid !== 1'b0) begin errors++; $display("[TB] FAIL async_valid actual %b required 0", bus.fetchValid); end
        checks++; if (bus.currentPc !== 32'h0) begin errors++; $display("[TB] FAIL async_pc actual %h required 0", bus.currentPc); end
        checks++; if (bus.pendingB !== 8'h0) begin errors++; $display("[TB] FAIL async_pendingB actual %h required 0", bus.pendingB); end
        checks++; if (bus.counter !== 3'h0) begin errors++; $display("[TB] FAIL async_counter actual %h required 0", bus.counter); end
        checks++; if (bus.correctPc !== 32'h0) begin errors++; $display("[TB] FAIL async_correctPc actual %h required 0", bus.correctPc); end
        checks++; if (bus.globalHistoryRegister !== 180'h0) begin errors++; $display("[TB] FAIL async_ghr actual %h required 0", bus.globalHistoryRegister); end
        #10;
        rstN = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_ghr_insert();
        test_counter();
        test_redirect();
        test_back_to_back();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
